// File: rtl/stream_fifo_pkg.sv
// ============================================================================
// Module      : stream_fifo_pkg
// Description : Shared constants and handshake helper for stream_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_fifo_pkg;

    localparam int STREAM_FIFO_DEPTH_DEFAULT = 1024;

    function automatic logic handshake(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo_ram.sv
// ============================================================================
// Module      : simple_dual_port_ram
// Description : One write port, one registered read port; rdata holds while
//               ren is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_dual_port_ram #(
    parameter int WIDTH      = 256,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  wclk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  rclk,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge wclk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (ren) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge rclk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/stream_fifo.sv
// ============================================================================
// Module      : stream_fifo
// Description : Valid/ready FIFO over a simple dual-port RAM whose read
//               register doubles as the output register. Optional build
//               macro STREAM_FIFO_LEVEL_EN adds level / almost_full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH        = 256,
    parameter int DEPTH        = STREAM_FIFO_DEPTH_DEFAULT
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    parameter int AFULL_THRESH = DEPTH - 2
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full
`endif
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  push, pop, fetch;
    logic [WIDTH-1:0]      rdata;

    // Ready looks only at the registered count, so no ready->valid comb path.
    assign in_ready = (mem_cnt_q != FULL_CNT) & rst_n;
    assign push     = handshake(in_valid, in_ready);
    assign pop      = handshake(out_valid_q, out_ready);
    assign fetch    = (mem_cnt_q != '0) & (!out_valid_q | out_ready);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mem_cnt_d   = mem_cnt_q;
        out_valid_d = fetch | (out_valid_q & !pop);
        if (push) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (fetch) begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
        end
        case ({push, fetch})
            2'b10:   mem_cnt_d = mem_cnt_q + (ADDR_WIDTH+1)'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - (ADDR_WIDTH+1)'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    simple_dual_port_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .wclk  (clk),
        .wen   (push),
        .waddr (wptr_q),
        .wdata (in_data),
        .rclk  (clk),
        .ren   (fetch),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    assign out_valid = out_valid_q;
    assign out_data  = rdata;

`ifdef STREAM_FIFO_LEVEL_EN
    assign level       = mem_cnt_q + {{ADDR_WIDTH{1'b0}}, out_valid_q};
    assign almost_full = 32'(level) >= AFULL_THRESH;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_fifo.sv
// ============================================================================
// Module      : tb_stream_fifo
// Description : Directed + random scoreboard bench for stream_fifo (8x4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef STREAM_FIFO_LEVEL_EN
    logic [2:0] level;
    logic       almost_full;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    int         accepted = 0;
    int         pops = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    stream_fifo #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef STREAM_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge: stall stability, scoreboard push and pop.
    task automatic sample();
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(in_data);
            accepted++;
        end
        if (out_valid && out_ready) begin
            pops++;
            if (sb_q.size() == 0) begin
                chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("sb_data", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && sb_q.size() > 0; i++) begin
            step();
        end
        chk("drain_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        int first_pop;
        int last_pop;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        adv();
        rst_n = 1'b1;
        sample();
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef STREAM_FIFO_LEVEL_EN
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_afull", {31'd0, almost_full}, 32'd0);
`endif
        adv();

        // Single word: valid two cycles after the push, gone one cycle later
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        sample();
        chk("single_c1_valid", {31'd0, out_valid}, 32'd0);
        adv();
        sample();
        chk("single_c2_valid", {31'd0, out_valid}, 32'd1);
        chk("single_c2_data", {24'd0, out_data}, 32'hA5);
        adv();
        sample();
        chk("single_c3_valid", {31'd0, out_valid}, 32'd0);
        adv();

        // Fill with consumer stalled: 4 in RAM + 1 in output register
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        in_valid = 1'b0;
        sample();
        chk("fill_accepted", accepted, 32'd5);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_out_valid", {31'd0, out_valid}, 32'd1);
        chk("fill_head", {24'd0, out_data}, 32'h01);
`ifdef STREAM_FIFO_LEVEL_EN
        chk("fill_level", {29'd0, level}, 32'd5);
        chk("fill_afull", {31'd0, almost_full}, 32'd1);
`endif
        adv();

        // Drain in order, one word per cycle; ready returns after first fetch
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            sample();
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_order", {24'd0, out_data}, 32'(i));
            if (i == 2) chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
            adv();
        end
        sample();
        chk("drain_done_valid", {31'd0, out_valid}, 32'd0);
`ifdef STREAM_FIFO_LEVEL_EN
        chk("drain_level", {29'd0, level}, 32'd0);
`endif
        adv();

        // Streaming through four pointer wraps with no bubbles
        pops      = 0;
        first_pop = -1;
        last_pop  = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            in_valid = (c < 16);
            in_data  = 8'(c);
            sample();
            if (out_valid) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            adv();
        end
        in_valid = 1'b0;
        chk("stream_pops", pops, 32'd16);
        chk("stream_first", first_pop, 32'd2);
        chk("stream_last", last_pop, 32'd17);

        // Random stalls on both sides
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain(40);

        // Reset with three words buffered
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h30 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        sb_q.delete();
        prev_stall = 1'b0;
        adv();
        rst_n = 1'b1;
        sample();
        chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef STREAM_FIFO_LEVEL_EN
        chk("postrst_level", {29'd0, level}, 32'd0);
`endif
        adv();
        in_valid  = 1'b1;
        in_data   = 8'h7E;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        sample();
        chk("postrst_first_valid", {31'd0, out_valid}, 32'd1);
        chk("postrst_first_data", {24'd0, out_data}, 32'h7E);
        adv();
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
